// File: rtl/blockmem_integrity_pkg.sv
`default_nettype none
// ============================================================================
// Module   : blockmem_integrity_pkg
// Purpose  : Shared types, cause codes and the address-window helper for the
//            multi-region memory-integrity monitor.
// Revision : 1.0 - initial multi-region release
// ============================================================================
package blockmem_integrity_pkg;

    // Widest address the helper accepts; callers zero-extend into it.
    localparam int c_ADDR_MAX = 32;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HOLD = 2'b01,
        ST_WAIT = 2'b10
    } state_t;

    // Violation source codes reported in cause_src.
    localparam logic [1:0] SRC_CPU_W = 2'b00;
    localparam logic [1:0] SRC_CPU_R = 2'b01;
    localparam logic [1:0] SRC_DMA   = 2'b10;

    // base <= addr < base+size. The end is formed one bit wider than the
    // operands so a window touching the top of the map never wraps to zero.
    function automatic logic in_range(
        input logic [c_ADDR_MAX-1:0] addr,
        input logic [c_ADDR_MAX-1:0] base,
        input logic [c_ADDR_MAX-1:0] size
    );
        logic [c_ADDR_MAX:0] w_end;
        w_end = {1'b0, base} + {1'b0, size};
        return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < w_end);
    endfunction

endpackage
`default_nettype wire

// File: rtl/blockmem_integrity_mr_if.sv
`default_nettype none
// ============================================================================
// Module   : blockmem_integrity_mr_if
// Purpose  : Access-observation and status bus of the integrity monitor.
//            master = CPU/DMA side that drives accesses, slave = monitor.
// Revision : 1.0 - initial multi-region release
// ============================================================================
interface blockmem_integrity_mr_if #(
    parameter int N_REGIONS = 2,
    parameter int ADDR_W    = 16,
    parameter int CNT_W     = 8
);
    localparam int c_REG_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

    logic [ADDR_W-1:0]    pc;
    logic [ADDR_W-1:0]    data_addr;
    logic                 w_en;
    logic                 r_en;
    logic [ADDR_W-1:0]    dma_addr;
    logic                 dma_en;
    logic [N_REGIONS-1:0] region_en;
    logic                 cause_clr;
    logic                 kill;
    logic                 cause_valid;
    logic [c_REG_W-1:0]   cause_region;
    logic [1:0]           cause_src;
    logic [CNT_W-1:0]     viol_count;

    modport master (
        output pc, data_addr, w_en, r_en, dma_addr, dma_en, region_en, cause_clr,
        input  kill, cause_valid, cause_region, cause_src, viol_count
    );

    modport slave (
        input  pc, data_addr, w_en, r_en, dma_addr, dma_en, region_en, cause_clr,
        output kill, cause_valid, cause_region, cause_src, viol_count
    );

endinterface
`default_nettype wire

// File: rtl/blockmem_region_match.sv
`default_nettype none
// ============================================================================
// Module   : blockmem_region_match
// Purpose  : Address match of CPU and DMA accesses against one protected
//            region; reports the region's read-protection flag alongside.
// Revision : 1.0 - initial multi-region release
// ============================================================================
module blockmem_region_match
    import blockmem_integrity_pkg::*;
#(
    parameter int               ADDR_W  = 16,
    parameter logic [ADDR_W-1:0] BASE   = '0,
    parameter logic [ADDR_W-1:0] SIZE   = '0,
    parameter logic             RD_PROT = 1'b0
) (
    input  logic              en,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [ADDR_W-1:0] dma_addr,
    output logic              cpu_hit,
    output logic              dma_hit,
    output logic              rd_prot
);

    // A zero-sized region is compiled out entirely.
    localparam logic c_ENABLED = (SIZE != '0);

    // Window compare for both bus masters, gated by the runtime enable.
    always_comb begin
        cpu_hit = en && c_ENABLED &&
                  in_range(c_ADDR_MAX'(data_addr), c_ADDR_MAX'(BASE), c_ADDR_MAX'(SIZE));
        dma_hit = en && c_ENABLED &&
                  in_range(c_ADDR_MAX'(dma_addr), c_ADDR_MAX'(BASE), c_ADDR_MAX'(SIZE));
        rd_prot = RD_PROT;
    end

endmodule
`default_nettype wire

// File: rtl/blockmem_integrity_mr.sv
`default_nettype none
// ============================================================================
// Module   : blockmem_integrity_mr
// Purpose  : Multi-region memory-integrity monitor. Flags untrusted CPU
//            writes/reads and any DMA access into protected regions, asserts
//            a held kill request, records the first cause and counts
//            violation cycles.
// Revision : 1.0 - initial multi-region release
// ============================================================================
module blockmem_integrity_mr
    import blockmem_integrity_pkg::*;
#(
    parameter int                          N_REGIONS     = 2,
    parameter int                          ADDR_W        = 16,
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE   = {16'h0600, 16'h0400},
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_SIZE   = {16'h0040, 16'h0106},
    parameter logic [N_REGIONS-1:0]        RD_PROT       = 2'b10,
    parameter logic [ADDR_W-1:0]           TCB_BASE      = 16'h0010,
    parameter logic [ADDR_W-1:0]           TCB_SIZE      = 16'h0010,
    parameter logic [ADDR_W-1:0]           SMEM_BASE     = 16'hA000,
    parameter logic [ADDR_W-1:0]           SMEM_SIZE     = 16'h4000,
    parameter logic [ADDR_W-1:0]           RESET_HANDLER = 16'h0000,
    parameter int                          KILL_HOLD     = 4,
    parameter int                          CNT_W         = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    blockmem_integrity_mr_if.slave    bus
);

    localparam int c_REG_W  = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
    localparam int c_HOLD_W = (KILL_HOLD > 1) ? $clog2(KILL_HOLD) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(KILL_HOLD - 1);

    // Trusted windows are inclusive up to base+size-2, i.e. half-open with
    // length size-1; a zero size collapses to an empty window.
    localparam logic [ADDR_W-1:0] c_TCB_SPAN  = (TCB_SIZE  == '0) ? '0 : TCB_SIZE  - 1'b1;
    localparam logic [ADDR_W-1:0] c_SMEM_SPAN = (SMEM_SIZE == '0) ? '0 : SMEM_SIZE - 1'b1;

    logic [N_REGIONS-1:0] w_cpu_hit;
    logic [N_REGIONS-1:0] w_dma_hit;
    logic [N_REGIONS-1:0] w_rd_prot;
    logic [N_REGIONS-1:0] w_viol_w;
    logic [N_REGIONS-1:0] w_viol_r;
    logic [N_REGIONS-1:0] w_viol_d;
    logic                 w_trusted;
    logic                 w_viol;
    logic [c_REG_W-1:0]   w_cause_region;
    logic [1:0]           w_cause_src;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_HOLD_W-1:0]  r_hold_cnt;
    logic [c_HOLD_W-1:0]  w_hold_nxt;
    logic                 r_kill;
    logic                 w_kill_nxt;

    logic                 r_cause_valid;
    logic [c_REG_W-1:0]   r_cause_region;
    logic [1:0]           r_cause_src;
    logic [CNT_W-1:0]     r_viol_count;

    for (genvar gi = 0; gi < N_REGIONS; gi++) begin : g_region
        blockmem_region_match #(
            .ADDR_W  (ADDR_W),
            .BASE    (REGION_BASE[gi*ADDR_W +: ADDR_W]),
            .SIZE    (REGION_SIZE[gi*ADDR_W +: ADDR_W]),
            .RD_PROT (RD_PROT[gi])
        ) u_match (
            .en        (bus.region_en[gi]),
            .data_addr (bus.data_addr),
            .dma_addr  (bus.dma_addr),
            .cpu_hit   (w_cpu_hit[gi]),
            .dma_hit   (w_dma_hit[gi]),
            .rd_prot   (w_rd_prot[gi])
        );
    end

    // PC lies in either trusted code window.
    always_comb begin
        w_trusted = in_range(c_ADDR_MAX'(bus.pc), c_ADDR_MAX'(TCB_BASE),  c_ADDR_MAX'(c_TCB_SPAN)) ||
                    in_range(c_ADDR_MAX'(bus.pc), c_ADDR_MAX'(SMEM_BASE), c_ADDR_MAX'(c_SMEM_SPAN));
    end

    // Per-region violation vectors for each source.
    always_comb begin
        w_viol_w = '0;
        w_viol_r = '0;
        w_viol_d = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            w_viol_w[i] = bus.w_en && w_cpu_hit[i] && !w_trusted;
            w_viol_r[i] = bus.r_en && w_rd_prot[i] && w_cpu_hit[i] && !w_trusted;
            w_viol_d[i] = bus.dma_en && w_dma_hit[i];
        end
        w_viol = (|w_viol_w) || (|w_viol_r) || (|w_viol_d);
    end

    // Cause priority: CPU write over CPU read over DMA, lowest region first.
    // Later assignments override earlier ones, so lower-priority sources and
    // higher region indices are written first.
    always_comb begin
        w_cause_src    = SRC_DMA;
        w_cause_region = '0;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if (w_viol_d[i]) w_cause_region = c_REG_W'(i);
        end
        if (|w_viol_r) begin
            w_cause_src = SRC_CPU_R;
            for (int i = N_REGIONS - 1; i >= 0; i--) begin
                if (w_viol_r[i]) w_cause_region = c_REG_W'(i);
            end
        end
        if (|w_viol_w) begin
            w_cause_src = SRC_CPU_W;
            for (int i = N_REGIONS - 1; i >= 0; i--) begin
                if (w_viol_w[i]) w_cause_region = c_REG_W'(i);
            end
        end
    end

    // State, hold counter and kill register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_WAIT;
            r_hold_cnt <= '0;
            r_kill     <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_kill     <= w_kill_nxt;
        end
    end

    // Next-state logic: any violation (re)starts the hold; re-arm only from
    // WAIT once the core sits at the reset handler.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_viol) begin
                    w_state_nxt = ST_HOLD;
                    w_hold_nxt  = c_HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (w_viol) begin
                    w_hold_nxt = c_HOLD_LOAD;
                end else if (r_hold_cnt == '0) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_hold_nxt = r_hold_cnt - c_HOLD_W'(1);
                end
            end
            ST_WAIT: begin
                if (w_viol) begin
                    w_state_nxt = ST_HOLD;
                    w_hold_nxt  = c_HOLD_LOAD;
                end else if (bus.pc == RESET_HANDLER) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_WAIT;
                w_hold_nxt  = '0;
            end
        endcase
    end

    // Output decode: kill is asserted in every state except RUN.
    always_comb begin
        w_kill_nxt = (w_state_nxt != ST_RUN);
    end

    // First-cause capture; a coincident new violation beats the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cause_valid  <= 1'b0;
            r_cause_region <= '0;
            r_cause_src    <= SRC_CPU_W;
        end else if (w_viol && (!r_cause_valid || bus.cause_clr)) begin
            r_cause_valid  <= 1'b1;
            r_cause_region <= w_cause_region;
            r_cause_src    <= w_cause_src;
        end else if (bus.cause_clr) begin
            r_cause_valid  <= 1'b0;
            r_cause_region <= '0;
            r_cause_src    <= SRC_CPU_W;
        end
    end

    // Saturating count of cycles carrying a violation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_viol_count <= '0;
        end else if (w_viol && (r_viol_count != '1)) begin
            r_viol_count <= r_viol_count + CNT_W'(1);
        end
    end

    assign bus.kill         = r_kill;
    assign bus.cause_valid  = r_cause_valid;
    assign bus.cause_region = r_cause_region;
    assign bus.cause_src    = r_cause_src;
    assign bus.viol_count   = r_viol_count;

endmodule
`default_nettype wire

// File: tb/tb_blockmem_integrity_mr.sv
`default_nettype none
// ============================================================================
// Module   : tb_blockmem_integrity_mr
// Purpose  : Self-checking bench for blockmem_integrity_mr: directed scenarios
//            followed by randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_blockmem_integrity_mr;

    localparam int c_N         = 2;
    localparam int c_KILL_HOLD = 4;

    logic clk;
    logic reset;

    int n_tests;
    int n_fail;

    // Model of the monitor in terms of the behavioural rules.
    int c_base [c_N] = '{32'h0400, 32'h0600};
    int c_size [c_N] = '{32'h0106, 32'h0040};
    bit c_rdp  [c_N] = '{1'b0, 1'b1};

    bit   m_armed;
    int   m_hold_left;
    bit   m_cvalid;
    int   m_creg;
    int   m_csrc;
    int   m_count;

    blockmem_integrity_mr_if #(.N_REGIONS(c_N), .ADDR_W(16), .CNT_W(8)) bus ();

    blockmem_integrity_mr dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit hit(input int a, input int i);
        return bus.region_en[i] && (c_size[i] != 0) && (a >= c_base[i]) && (a < c_base[i] + c_size[i]);
    endfunction

    // One clock: advance the model from the pre-edge inputs, then compare.
    task automatic step();
        int  p;
        int  da;
        int  ma;
        bit  trusted;
        bit  found;
        int  reg_i;
        int  src;
        p     = int'(bus.pc);
        da    = int'(bus.data_addr);
        ma    = int'(bus.dma_addr);
        trusted = ((p >= 32'h0010) && (p <= 32'h0010 + 32'h0010 - 2)) ||
                  ((p >= 32'hA000) && (p <= 32'hA000 + 32'h4000 - 2));
        found = 1'b0;
        reg_i = 0;
        src   = 0;
        for (int i = 0; i < c_N; i++)
            if (!found && bus.w_en && !trusted && hit(da, i)) begin found = 1'b1; reg_i = i; src = 0; end
        for (int i = 0; i < c_N; i++)
            if (!found && bus.r_en && c_rdp[i] && !trusted && hit(da, i)) begin found = 1'b1; reg_i = i; src = 1; end
        for (int i = 0; i < c_N; i++)
            if (!found && bus.dma_en && hit(ma, i)) begin found = 1'b1; reg_i = i; src = 2; end

        @(posedge clk);
        if (reset) begin
            m_armed = 1'b0; m_hold_left = 0;
            m_cvalid = 1'b0; m_creg = 0; m_csrc = 0; m_count = 0;
        end else begin
            if (found) begin
                m_armed = 1'b0;
                m_hold_left = c_KILL_HOLD;
            end else if (!m_armed) begin
                if (m_hold_left > 0) m_hold_left--;
                else if (p == 0) m_armed = 1'b1;
            end
            if (found && (!m_cvalid || bus.cause_clr)) begin
                m_cvalid = 1'b1; m_creg = reg_i; m_csrc = src;
            end else if (bus.cause_clr) begin
                m_cvalid = 1'b0; m_creg = 0; m_csrc = 0;
            end
            if (found && m_count < 255) m_count++;
        end
        #1;
        check_eq("kill",         32'(bus.kill),         32'(!m_armed));
        check_eq("cause_valid",  32'(bus.cause_valid),  32'(m_cvalid));
        check_eq("cause_region", 32'(bus.cause_region), m_creg);
        check_eq("cause_src",    32'(bus.cause_src),    m_csrc);
        check_eq("viol_count",   32'(bus.viol_count),   m_count);
    endtask

    task automatic idle();
        bus.w_en = 1'b0; bus.r_en = 1'b0; bus.dma_en = 1'b0; bus.cause_clr = 1'b0;
    endtask

    function automatic logic [15:0] pick_pc();
        logic [15:0] t [7] = '{16'h0000, 16'h001E, 16'h001F, 16'hDFFE, 16'hDFFF, 16'h1200, 16'h0010};
        int k;
        k = int'($urandom_range(0, 7));
        return (k == 7) ? 16'($urandom) : t[k];
    endfunction

    function automatic logic [15:0] pick_addr();
        logic [15:0] t [8] = '{16'h03FF, 16'h0400, 16'h0505, 16'h0506, 16'h05FF, 16'h0600, 16'h063F, 16'h0640};
        int k;
        k = int'($urandom_range(0, 8));
        return (k == 8) ? 16'($urandom) : t[k];
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_armed = 1'b0; m_hold_left = 0; m_cvalid = 1'b0; m_creg = 0; m_csrc = 0; m_count = 0;
        reset = 1'b1;
        idle();
        bus.pc = 16'h0000; bus.data_addr = '0; bus.dma_addr = '0; bus.region_en = 2'b11;
        repeat (3) step();
        check_eq("reset_kill", 32'(bus.kill), 32'd1);

        // Release with PC at the handler: re-arms.
        reset = 1'b0;
        repeat (2) step();
        check_eq("armed_kill", 32'(bus.kill), 32'd0);

        // Untrusted write into region 0 for one cycle.
        bus.pc = 16'h1200; bus.w_en = 1'b1; bus.data_addr = 16'h0480;
        step();
        idle();
        repeat (6) step();
        check_eq("wr_cause_src", 32'(bus.cause_src), 32'd0);
        check_eq("wr_count", 32'(bus.viol_count), 32'd1);
        bus.pc = 16'h0000; repeat (2) step();

        // Trusted write, and a write one past region 0: no violation.
        bus.pc = 16'h0014; bus.w_en = 1'b1; bus.data_addr = 16'h0480; step();
        bus.pc = 16'h1200; bus.data_addr = 16'h0506; step();
        idle(); step();
        check_eq("no_viol_kill", 32'(bus.kill), 32'd0);

        // Reads: unprotected region 0, then protected region 1.
        bus.cause_clr = 1'b1; step(); idle();
        bus.r_en = 1'b1; bus.data_addr = 16'h0400; step();
        bus.data_addr = 16'h0610; step();
        idle(); repeat (6) step();
        bus.pc = 16'h0000; repeat (2) step();

        // DMA to region 0 with CPU write to region 1; then all regions off.
        bus.cause_clr = 1'b1; step(); idle();
        bus.pc = 16'h1200;
        bus.dma_en = 1'b1; bus.dma_addr = 16'h0400; bus.w_en = 1'b1; bus.data_addr = 16'h0600;
        bus.cause_clr = 1'b1; step();
        check_eq("dma_wr_region", 32'(bus.cause_region), 32'd1);
        bus.cause_clr = 1'b0; bus.region_en = 2'b00; repeat (6) step();
        idle(); bus.region_en = 2'b11;

        // Saturation under a sustained DMA violation.
        bus.dma_en = 1'b1; bus.dma_addr = 16'h0400;
        repeat (300) step();
        check_eq("sat_count", 32'(bus.viol_count), 32'hFF);
        // Clear coinciding with a new read violation.
        bus.dma_en = 1'b0; bus.r_en = 1'b1; bus.data_addr = 16'h063F; bus.cause_clr = 1'b1;
        step();
        check_eq("clr_viol_src", 32'(bus.cause_src), 32'd1);
        idle();
        // Reset while in HOLD.
        step();
        reset = 1'b1; step();
        check_eq("rst_hold_count", 32'(bus.viol_count), 32'd0);
        reset = 1'b0;

        // Randomized traffic.
        for (int it = 0; it < 3000; it++) begin
            bus.pc        = pick_pc();
            bus.data_addr = pick_addr();
            bus.dma_addr  = pick_addr();
            bus.w_en      = ($urandom_range(0, 7) == 0);
            bus.r_en      = ($urandom_range(0, 7) == 0);
            bus.dma_en    = ($urandom_range(0, 9) == 0);
            bus.cause_clr = ($urandom_range(0, 15) == 0);
            bus.region_en = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            reset         = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
